mdu_ctrl: RTL
=============

# mdu_ctrl

Multi-cycle RV32M multiply/divide controller sitting in the execute stage beside the single-cycle ALU. It accepts an M-extension operation with its two register operands and sequences an iterative shift-add multiply or restoring divide. It holds `busy` to stall the pipeline until the result is ready, then pulses `done` with the 32-bit result for write-back.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort of an in-flight operation.
- `fun3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `ReadData1`  in  32  rs1 operand (multiplicand / dividend).
- `ReadData2`  in  32  rs2 operand (multiplier / divisor).
- `busy`  out  1  high whenever the state is not IDLE; pipeline stall.
- `done`  out  1  one-cycle pulse; `MDU_Result` is valid in that cycle.
- `MDU_Result`  out  32  result; held until the next accepted `start`.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE. Iteration counter is 5 bits.
- IDLE: when `start`=1, latch `fun3` and both operands, then go to PREP. `start` is ignored in every other state.
- PREP:
  - Record operand signs. rs1 is signed for MUL, MULH, MULHSU, DIV, REM. rs2 is signed for MUL, MULH, DIV, REM.
  - Convert signed negative operands to magnitudes.
  - Detect special cases. If one applies, load the result and go directly to DONE. Otherwise clear the counter and go to CALC.
- Special cases:
  - Divisor 0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = dividend unchanged.
  - DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- CALC: exactly 32 cycles, one bit per cycle.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and 33-bit partial remainder.
  - Counter wraps 31→0 on the last iteration; that cycle transitions to FIX.
- FIX: sign correction.
  - Product: negate the 64-bit value if the effective signs differ.
  - Quotient: negative iff the operand signs differ (DIV only).
  - Remainder: takes the sign of the dividend (REM only).
  - Result selection: MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
- DONE: `done`=1 and `MDU_Result` is driven. Next state is IDLE.
- `flush`=1 in any non-IDLE state: next state is IDLE, no `done`, and `MDU_Result` is unchanged. `flush` in IDLE is a no-op.
- Priority: `rst` over `flush`, and `flush` over state advance.

## Timing
- Reset values: `busy`=0, `done`=0, `MDU_Result`=0, state IDLE, counter 0, internal registers 0.
- `start` is accepted in cycle N. The state sequence is:
  - N+1: PREP.
  - N+2 to N+33: CALC.
  - N+34: FIX.
  - N+35: DONE, with `done`=1.
  - N+36: IDLE.
- Special-case path: PREP at N+1, DONE at N+2.
- `busy` is high from N+1 through the DONE cycle inclusive.
- `start` high in the DONE cycle is ignored. The earliest back-to-back accept is the first IDLE cycle (N+36).
- `rst` mid-operation: all outputs are at reset values in the following cycle; the operation is lost.

## Configuration
- `MDU_FAST_MUL_EN`:
  - Defined: MUL/MULH/MULHSU/MULHU compute a 64-bit product combinationally in PREP with `*` on sign-extended 33-bit operands, then go directly to DONE (`done` at N+2).
  - Undefined: multiplies use the iterative CALC/FIX path (`done` at N+35).
  - Division timing is identical either way.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD → `done` at N+35, result 0xFFFFFFEB; `busy` high N+1..N+35.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with `done` at N+2. REM 0x80000000/0xFFFFFFFF → 0 with `done` at N+2.
- `start` re-asserted at N+5 → ignored. `flush` at N+10 → IDLE at N+11, no `done`, `MDU_Result` unchanged. A new `start` at N+11 then completes normally at N+46.
- `rst` at N+20 → `busy`/`done`/`MDU_Result` = 0 at N+21. With `MDU_FAST_MUL_EN`, MUL 3×4 → 12 with `done` at N+2.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide controller.
interface mdu_ctrl_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      fun3;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] MDU_Result;

    modport master (output start, flush, fun3, ReadData1, ReadData2,
                    input  busy, done, MDU_Result);
    modport slave  (input  start, flush, fun3, ReadData1, ReadData2,
                    output busy, done, MDU_Result);
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) controller with pipeline stall.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies computed in PREP with a '*' operator.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [4:0]        cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opa, opb;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quot, rem;
    logic              busy, done;
    logic [XLEN-1:0]   result;

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.MDU_Result = result;

    // Operand signedness from funct3: MULHU/DIVU/REMU unsigned, MULHSU only rs1 signed.
    logic            is_div, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    assign is_div      = op[2];
    assign a_signed    = is_div ? ~op[0] : (op[1:0] != 2'b11);
    assign b_signed    = is_div ? ~op[0] : ~op[1];
    assign neg_a       = a_signed & opa[XLEN-1];
    assign neg_b       = b_signed & opb[XLEN-1];
    assign abs_a       = neg_a ? -opa : opa;
    assign abs_b       = neg_b ? -opb : opb;
    assign div_zero    = is_div & (opb == '0);
    assign div_ovf     = is_div & ~op[0] & (opa == INT_MIN) & (opb == '1);
    assign special_res = div_zero ? (op[1] ? opa : '1) : (op[1] ? '0 : INT_MIN);

    // One multiply step: add multiplicand into the upper half, shift the carry back in.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});

    // One restoring divide step on the 33-bit shifted partial remainder.
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            q_bit;
    assign rem_sh  = {rem, quot[XLEN-1]};
    assign q_bit   = (rem_sh >= {1'b0, mag_b});
    assign rem_sub = rem_sh[XLEN-1:0] - mag_b;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, quot_fix, rem_fix, fix_res;
    assign prod     = (sign_a ^ sign_b) ? -acc : acc;
    assign mul_res  = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign quot_fix = (sign_a ^ sign_b) ? -quot : quot;
    assign rem_fix  = sign_a ? -rem : rem;
    assign fix_res  = is_div ? (op[1] ? rem_fix : quot_fix) : mul_res;

`ifdef MDU_FAST_MUL_EN
    logic [XLEN:0]     fa, fb;
    logic [2*XLEN-1:0] fprod;
    logic [XLEN-1:0]   fast_res;
    assign fa       = {a_signed & opa[XLEN-1], opa};
    assign fb       = {b_signed & opb[XLEN-1], opb};
    assign fprod    = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
    assign fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            opa    <= '0;
            opb    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            quot   <= '0;
            rem    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (bus.flush && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        op    <= bus.fun3;
                        opa   <= bus.ReadData1;
                        opb   <= bus.ReadData2;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    mag_a  <= abs_a;
                    mag_b  <= abs_b;
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) begin
                        result <= fast_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else
`endif
                    if (div_zero || div_ovf) begin
                        result <= special_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt   <= '0;
                        acc   <= {{XLEN{1'b0}}, abs_b};
                        quot  <= abs_a;
                        rem   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        rem  <= q_bit ? rem_sub : rem_sh[XLEN-1:0];
                        quot <= {quot[XLEN-2:0], q_bit};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
